sa_fifo_reader: RTL and testbench

Read-side consumer for the systolic-array write FIFO. It pops FIFO_ENTRY_t {addr, data} entries through the FIFO's rd_en/empty/data_out interface and replays them as writes on a valid/ready memory write port, such as a weight or activation scratchpad. A 2-entry skid buffer absorbs the FIFO's one-cycle read latency so that memory backpressure never drops or duplicates an entry. A drain command empties the FIFO and skid buffer, then pulses done.

---
 rtl/sa_pkg.sv | 20 ++
 rtl/sa_skid2.sv | 62 ++++++
 rtl/sa_fifo_reader.sv | 110 +++++++++++
 tb/tb_sa_fifo_reader.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sa_pkg.sv
// sa_pkg: types shared by the systolic-array write FIFO, its reader and the array
// Holds the FIFO entry layout {addr, data} and the reader state encoding.
package sa_pkg;

    localparam int SA_ADDR_W = 8;
    localparam int SA_DATA_W = 16;

    typedef struct packed {
        logic [SA_ADDR_W-1:0] addr;
        logic [SA_DATA_W-1:0] data;
    } FIFO_ENTRY_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/sa_skid2.sv
// sa_skid2: 2-entry in-order valid/ready queue of FIFO_ENTRY_t
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   in_valid_i/in_data_i/in_ready_o     write side
//   out_valid_o/out_data_o/out_ready_i  read side, head of queue
//   occ_o             current occupancy, 0..2
module sa_skid2
    import sa_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid_i,
    input  FIFO_ENTRY_t in_data_i,
    output logic        in_ready_o,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output FIFO_ENTRY_t out_data_o,
    output logic [1:0]  occ_o
);

    logic [1:0]  occ_q, occ_d;
    FIFO_ENTRY_t head_q, head_d, tail_q, tail_d;
    logic        push, pop;

    assign out_valid_o = occ_q != 2'd0;
    assign out_data_o  = head_q;
    assign occ_o       = occ_q;
    assign pop         = out_valid_o & out_ready_i;
    // A full queue can still take an entry when the head leaves this cycle.
    assign in_ready_o  = (occ_q != 2'd2) | pop;
    assign push        = in_valid_i & in_ready_o;

    always_comb begin
        occ_d  = occ_q + {1'b0, push} - {1'b0, pop};
        head_d = pop ? tail_q : head_q;
        tail_d = tail_q;
        // The new entry lands in the head when it is the only one left after this cycle.
        if (push && occ_d == 2'd1)
            head_d = in_data_i;
        else if (push)
            tail_d = in_data_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q  <= 2'd0;
            head_q <= '0;
            tail_q <= '0;
        end else begin
            occ_q  <= occ_d;
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst)
            assert (!(in_valid_i && !in_ready_o))
                else $error("sa_skid2 overflow: push into full queue");
    end

endmodule

// File: rtl/sa_fifo_reader.sv
// sa_fifo_reader: pops {addr,data} entries from the write FIFO and replays them on a valid/ready memory port
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   enable                    allow pops from the FIFO
//   drain_req                 pulse: empty FIFO and skid buffer, then pulse drain_done
//   fifo_empty, fifo_data_out FIFO status and read data (valid the cycle after fifo_rd_en)
//   fifo_rd_en                FIFO pop request
//   mem_wr_valid/ready/addr/data  memory write port
//   wr_count                  writes accepted since reset or last drain_done
//   addr_err                  sticky: an entry above ADDR_LIMIT was popped and dropped
//   busy, drain_done          state != IDLE, drain completion pulse
module sa_fifo_reader
    import sa_pkg::*;
#(
    parameter int ADDR_W     = SA_ADDR_W,
    parameter int DATA_W     = SA_DATA_W,
    parameter int CNT_W      = 16,
    parameter int ADDR_LIMIT = 2**ADDR_W - 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              drain_req,
    input  logic              fifo_empty,
    input  FIFO_ENTRY_t       fifo_data_out,
    output logic              fifo_rd_en,
    output logic              mem_wr_valid,
    input  logic              mem_wr_ready,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    output logic [CNT_W-1:0]  wr_count,
    output logic              addr_err,
    output logic              busy,
    output logic              drain_done
);

    localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(ADDR_LIMIT);

    state_t             state_q, state_d;
    logic               inflight_q;
    logic               addr_err_q, addr_err_d;
    logic [CNT_W-1:0]   wr_count_q, wr_count_d;
    logic               accept, cap_ok, cap_bad, reading, credit, skid_ready;
    logic [1:0]         occ;
    logic [2:0]         occ_next;
    FIFO_ENTRY_t        head;

    assign accept  = mem_wr_valid & mem_wr_ready;
    assign cap_bad = inflight_q & (fifo_data_out.addr > LIMIT);
    assign cap_ok  = inflight_q & ~cap_bad;
    assign reading = (state_q == RUN && enable) || state_q == DRAIN;
    // Credits count the skid slots left after this cycle's accept, minus the entry still in flight,
    // so a new read can never overflow the skid while still allowing one write per cycle.
    assign credit   = ({1'b0, occ} - {2'b0, accept} + {2'b0, inflight_q}) < 3'd2;
    assign occ_next = {1'b0, occ} - {2'b0, accept} + {2'b0, cap_ok};

    assign fifo_rd_en  = reading & ~fifo_empty & credit;
    assign mem_wr_addr = head.addr;
    assign mem_wr_data = head.data;
    assign wr_count    = wr_count_q;
    assign addr_err    = addr_err_q;
    assign busy        = state_q != IDLE;
    assign drain_done  = state_q == DONE;

    sa_skid2 u_skid (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (cap_ok),
        .in_data_i   (fifo_data_out),
        .in_ready_o  (skid_ready),
        .out_valid_o (mem_wr_valid),
        .out_ready_i (mem_wr_ready),
        .out_data_o  (head),
        .occ_o       (occ)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = drain_req ? DRAIN : enable ? RUN : IDLE;
            RUN:     state_d = drain_req ? DRAIN : enable ? RUN : IDLE;
            // Empty FIFO means no read this cycle, so nothing is in flight after the edge.
            DRAIN:   state_d = (fifo_empty && occ_next == 3'd0) ? DONE : DRAIN;
            default: state_d = IDLE;
        endcase
        addr_err_d = addr_err_q | cap_bad;
        wr_count_d = (state_q == DONE) ? '0 : wr_count_q + CNT_W'(accept);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            inflight_q <= 1'b0;
            addr_err_q <= 1'b0;
            wr_count_q <= '0;
        end else begin
            state_q    <= state_d;
            inflight_q <= fifo_rd_en;
            addr_err_q <= addr_err_d;
            wr_count_q <= wr_count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst)
            assert (!(cap_ok && !skid_ready))
                else $error("sa_fifo_reader: captured entry found no skid slot");
    end

endmodule

// File: tb/tb_sa_fifo_reader.sv
// tb_sa_fifo_reader: directed + randomized bench with a FIFO model and an in-order write scoreboard
module tb_sa_fifo_reader;
    import sa_pkg::*;

    localparam int LIM = 15;

    logic        clk = 1'b0;
    logic        rst, enable, drain_req, fifo_empty, fifo_rd_en;
    logic        mem_wr_valid, mem_wr_ready, addr_err, busy, drain_done;
    FIFO_ENTRY_t fifo_data_out;
    logic [7:0]  mem_wr_addr;
    logic [15:0] mem_wr_data, wr_count;

    always #5 clk = ~clk;

    sa_fifo_reader #(.ADDR_LIMIT(LIM)) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .drain_req     (drain_req),
        .fifo_empty    (fifo_empty),
        .fifo_data_out (fifo_data_out),
        .fifo_rd_en    (fifo_rd_en),
        .mem_wr_valid  (mem_wr_valid),
        .mem_wr_ready  (mem_wr_ready),
        .mem_wr_addr   (mem_wr_addr),
        .mem_wr_data   (mem_wr_data),
        .wr_count      (wr_count),
        .addr_err      (addr_err),
        .busy          (busy),
        .drain_done    (drain_done)
    );

    FIFO_ENTRY_t fq[$];
    FIFO_ENTRY_t exp_q[$];
    FIFO_ENTRY_t pend;
    logic        have_pend, err_model, pv, pr;
    logic [7:0]  pa;
    logic [15:0] pd;
    int passed = 0, total = 0;
    int cyc = 0, cnt_model = 0, pops = 0, accs = 0, drops = 0, done_seen = 0;
    int first_rd, first_acc, last_acc, done_cyc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
        total++;
        assert (obs === req) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, req);
    endtask

    task automatic push_entry(input logic [7:0] a, input logic [15:0] d);
        FIFO_ENTRY_t e;
        e.addr = a;
        e.data = d;
        fq.push_back(e);
        if (a <= LIM) exp_q.push_back(e);
    endtask

    task automatic step(input logic en, input logic rdy, input logic drq, input logic r);
        FIFO_ENTRY_t e;
        @(negedge clk);
        enable = en;
        mem_wr_ready = rdy;
        drain_req = drq;
        rst = r;
        if (have_pend) begin
            fifo_data_out = pend;
            if (pend.addr > LIM) begin
                drops++;
                err_model = 1'b1;
            end
            have_pend = 1'b0;
        end
        fifo_empty = fq.size() == 0;
        #1;
        if (r) begin
            fq.delete();
            exp_q.delete();
            have_pend = 1'b0;
            err_model = 1'b0;
            cnt_model = 0;
            pops = 0;
            accs = 0;
            drops = 0;
            pv = 1'b0;
        end else begin
            cyc++;
            if (fifo_rd_en) begin
                chk("rd_while_empty", fifo_empty, 1'b0);
                if (fq.size() != 0) begin
                    pend = fq.pop_front();
                    have_pend = 1'b1;
                    pops++;
                end
                if (first_rd < 0) first_rd = cyc;
            end
            if (pv && !pr) begin
                chk("hold_valid", mem_wr_valid, 1'b1);
                chk("hold_addr", mem_wr_addr, pa);
                chk("hold_data", mem_wr_data, pd);
            end
            chk("wr_count", wr_count, cnt_model);
            if (mem_wr_valid && mem_wr_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", 1'b1, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_addr", mem_wr_addr, e.addr);
                    chk("wr_data", mem_wr_data, e.data);
                end
                accs++;
                cnt_model++;
                last_acc = cyc;
                if (first_acc < 0) first_acc = cyc;
            end
            chk("held_le_2", (pops - accs - drops) <= 2, 1'b1);
            if (drain_done) begin
                done_seen++;
                done_cyc = cyc;
                chk("done_left_over", exp_q.size() + fq.size(), 0);
                cnt_model = 0;
            end
            pv = mem_wr_valid;
            pr = mem_wr_ready;
            pa = mem_wr_addr;
            pd = mem_wr_data;
        end
    endtask

    task automatic chk_zero();
        chk("z_rd_en", fifo_rd_en, 0);
        chk("z_valid", mem_wr_valid, 0);
        chk("z_addr", mem_wr_addr, 0);
        chk("z_data", mem_wr_data, 0);
        chk("z_count", wr_count, 0);
        chk("z_err", addr_err, 0);
        chk("z_busy", busy, 0);
        chk("z_done", drain_done, 0);
    endtask

    task automatic do_drain(input logic rand_rdy);
        int d0;
        d0 = done_seen;
        step(1'b0, 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 200 && done_seen == d0; k++)
            step(1'b0, rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1, 1'b0, 1'b0);
        chk("drain_done_seen", done_seen - d0, 1);
    endtask

    initial begin
        int n, d0;
        rst = 1'b1; enable = 1'b0; drain_req = 1'b0; fifo_empty = 1'b1; mem_wr_ready = 1'b0;
        fifo_data_out = '0; have_pend = 1'b0; err_model = 1'b0; pv = 1'b0; pr = 1'b0; pa = '0; pd = '0;
        first_rd = -1; first_acc = -1; last_acc = -1; done_cyc = -1; pend = '0;

        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk_zero();

        // basic stream: 11 writes, 2-cycle first latency, back-to-back
        for (int i = 0; i <= 10; i++) push_entry(8'(i), 16'(i));
        first_rd = -1; first_acc = -1; n = accs;
        for (int k = 0; k < 18; k++) step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("basic_writes", accs - n, 11);
        chk("basic_latency", first_acc - first_rd, 2);
        chk("basic_back2back", last_acc - first_acc, 10);
        chk("basic_wr_count", wr_count, 11);
        chk("basic_busy", busy, 1);

        // backpressure: ready pattern 1,0,0,1
        for (int i = 0; i < 8; i++) push_entry(8'(i), 16'($urandom));
        for (int k = 0; k < 40; k++) step(1'b1, (k % 4 == 0) || (k % 4 == 3), 1'b0, 1'b0);
        chk("bp_all_written", exp_q.size(), 0);
        chk("bp_wr_count", wr_count, 19);

        // concurrent fill/drain with gaps in the FIFO
        n = 11;
        for (int k = 0; k < 120 && (n <= 20 || exp_q.size() != 0); k++) begin
            step(1'b1, 1'($urandom_range(0, 3) != 0), 1'b0, 1'b0);
            if (n <= 20 && $urandom_range(0, 1) == 1) begin
                push_entry(8'(n & 15), 16'(n));
                n++;
            end
        end
        chk("conc_all_written", exp_q.size(), 0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("conc_wr_count", wr_count, 29);
        chk("idle_busy", busy, 0);

        // drain with enable low
        for (int i = 0; i < 5; i++) push_entry(8'(i + 3), 16'($urandom));
        n = accs;
        do_drain(1'b0);
        chk("drain_writes", accs - n, 5);
        chk("drain_after_last", done_cyc > last_acc, 1'b1);
        d0 = done_seen;
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("drain_count_zero", wr_count, 0);
        chk("drain_busy", busy, 0);
        for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("drain_single_pulse", done_seen, d0);

        // address error: 16 is dropped
        chk("err_before", addr_err, 0);
        push_entry(8'd14, 16'($urandom));
        push_entry(8'd16, 16'($urandom));
        push_entry(8'd15, 16'($urandom));
        for (int k = 0; k < 10; k++) step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("err_set", addr_err, 1);
        chk("err_wr_count", wr_count, 2);
        chk("err_all_written", exp_q.size(), 0);

        // randomized traffic with out-of-range addresses and random backpressure
        for (int k = 0; k < 250; k++) begin
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
            if (k < 180 && $urandom_range(0, 2) != 0)
                push_entry(8'($urandom_range(0, 31)), 16'($urandom));
        end
        do_drain(1'b1);
        chk("rand_all_written", exp_q.size(), 0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("rand_err_sticky", addr_err, err_model);
        chk("rand_err_set", addr_err, 1);

        // reset mid-stream with one entry in the skid and one in flight
        for (int i = 0; i < 6; i++) push_entry(8'(i), 16'($urandom));
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk_zero();
        n = accs;
        for (int k = 0; k < 5; k++) step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("rst_no_write", accs - n, 0);
        chk("rst_valid", mem_wr_valid, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
